// File: rtl/mpadd_sequencer.sv
// mpadd_sequencer: word-serial multi-precision add/subtract that streams operand words LSW first
// through one shared Ling carry-lookahead adder, chaining the carry in a register.
module mpadd_ling_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    logic [WIDTH-1:0] g, t;
    logic [WIDTH:1]   h;
    logic [WIDTH:0]   c;
    // Ling pseudo-carry h[i+1] = g[i] | t[i-1]&h[i]; real carry recovered as t[i] & h[i+1]
    always_comb begin
        g = a_i & b_i;
        t = a_i | b_i;
        h = '0;
        c = '0;
        c[0] = cin_i;
        for (int i = 0; i < WIDTH; i++) begin
            h[i+1] = g[i] | c[i];
            c[i+1] = t[i] & h[i+1];
        end
    end
    assign sum_o  = a_i ^ b_i ^ c[WIDTH-1:0];
    assign cout_o = c[WIDTH];
endmodule

module mpadd_sequencer #(
    parameter int WIDTH  = 32,
    parameter int NWORDS = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [NWORDS*WIDTH-1:0] in_a_i,
    input  logic [NWORDS*WIDTH-1:0] in_b_i,
    input  logic                    in_sub_i,
    input  logic                    in_cin_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [NWORDS*WIDTH-1:0] out_sum_o,
    output logic                    out_cout_o,
    output logic                    out_ovf_o,
    output logic                    busy_o
);
    localparam int N  = NWORDS * WIDTH;
    localparam int CW = NWORDS > 1 ? $clog2(NWORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, sub_q, sub_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [N-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [WIDTH-1:0] wa, wb, ws;
    logic             wc;

    assign wa = a_q[int'(cnt_q)*WIDTH +: WIDTH];
    assign wb = b_q[int'(cnt_q)*WIDTH +: WIDTH] ^ {WIDTH{sub_q}};

    mpadd_ling_adder #(.WIDTH(WIDTH)) u_add (
        .a_i   (wa),
        .b_i   (wb),
        .cin_i (carry_q),
        .sum_o (ws),
        .cout_o(wc)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: if (in_valid_i) begin
                a_d     = in_a_i;
                b_d     = in_b_i;
                sub_d   = in_sub_i;
                carry_d = in_sub_i ^ in_cin_i;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                sum_d[int'(cnt_q)*WIDTH +: WIDTH] = ws;
                carry_d = wc;
                if (cnt_q == LAST) begin
                    cout_d  = wc;
                    ovf_d   = (wa[WIDTH-1] == wb[WIDTH-1]) && (ws[WIDTH-1] != wa[WIDTH-1]);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready_o  = state_q == IDLE;
    assign out_valid_o = state_q == DONE;
    assign busy_o      = state_q != IDLE;
    assign out_sum_o   = sum_q;
    assign out_cout_o  = cout_q;
    assign out_ovf_o   = ovf_q;
endmodule

// File: tb/tb_mpadd_sequencer.sv
// tb_mpadd_sequencer: directed and randomized checks of mpadd_sequencer against an arithmetic model.
module tb_mpadd_sequencer;
    localparam int WIDTH  = 32;
    localparam int NWORDS = 4;
    localparam int N      = NWORDS * WIDTH;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0, in_sub = 1'b0, in_cin = 1'b0, out_ready = 1'b0;
    logic [N-1:0] in_a = '0, in_b = '0;
    logic         in_ready, out_valid, out_cout, out_ovf, busy;
    logic [N-1:0] out_sum;
    int           n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    mpadd_sequencer #(.WIDTH(WIDTH), .NWORDS(NWORDS)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_a_i     (in_a),
        .in_b_i     (in_b),
        .in_sub_i   (in_sub),
        .in_cin_i   (in_cin),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_sum_o  (out_sum),
        .out_cout_o (out_cout),
        .out_ovf_o  (out_ovf),
        .busy_o     (busy)
    );

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] rnd();
        logic [N-1:0] v;
        for (int i = 0; i < NWORDS; i++) v[i*WIDTH +: WIDTH] = $urandom;
        return v;
    endfunction

    // Unsigned and sign-extended arithmetic on the whole operand; carry and overflow fall out of the wide result.
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s, input logic c,
                         output logic [N-1:0] sum, output logic co, output logic ov);
        logic [N:0]   u;
        logic [N+1:0] sx;
        if (!s) begin
            u  = {1'b0, a} + {1'b0, b} + (N+1)'(c);
            co = u[N];
            sx = {{2{a[N-1]}}, a} + {{2{b[N-1]}}, b} + (N+2)'(c);
        end else begin
            u  = {1'b0, a} - {1'b0, b} - (N+1)'(c);
            co = {1'b0, a} >= {1'b0, b} + (N+1)'(c);
            sx = {{2{a[N-1]}}, a} - {{2{b[N-1]}}, b} - (N+2)'(c);
        end
        sum = u[N-1:0];
        ov  = sx[N] != sx[N-1];
    endtask

    task automatic accept(input logic [N-1:0] a, input logic [N-1:0] b, input logic s, input logic c);
        int n = 0;
        @(negedge clk);
        in_a = a; in_b = b; in_sub = s; in_cin = c; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_accept", N'(in_ready), N'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_a = rnd(); in_b = rnd(); in_sub = $urandom; in_cin = $urandom;
    endtask

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s, input logic c,
                         input int hold);
        logic [N-1:0] es;
        logic         ec, eo;
        model(a, b, s, c, es, ec, eo);
        accept(a, b, s, c);
        for (int k = 1; k <= NWORDS; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("out_valid_at_%0d", k), N'(out_valid), N'(k == NWORDS));
            if (k == 1) chk("busy_in_run", N'(busy), N'(1));
        end
        chk("out_sum", out_sum, es);
        chk("out_cout", N'(out_cout), N'(ec));
        chk("out_ovf", N'(out_ovf), N'(eo));
        chk("in_ready_done", N'(in_ready), N'(0));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; in_a = rnd(); in_b = rnd();
            @(posedge clk);
            #1;
            chk("hold_valid", N'(out_valid), N'(1));
            chk("hold_in_ready", N'(in_ready), N'(0));
            chk("hold_sum", out_sum, es);
            chk("hold_flags", N'({out_cout, out_ovf}), N'({ec, eo}));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("valid_after_handshake", N'(out_valid), N'(0));
        chk("ready_after_handshake", N'(in_ready), N'(1));
        chk("busy_after_handshake", N'(busy), N'(0));
    endtask

    initial begin
        logic [N-1:0] ones, smax;
        ones = '1;
        smax = {1'b0, {(N-1){1'b1}}};
        #12;
        chk("reset_in_ready", N'(in_ready), N'(1));
        chk("reset_out_valid", N'(out_valid), N'(0));
        chk("reset_busy", N'(busy), N'(0));
        chk("reset_sum", out_sum, '0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(ones, N'(1), 1'b0, 1'b0, 0);
        do_op({{(N/2){1'b0}}, {(N/2){1'b1}}}, N'(1), 1'b0, 1'b0, 0);
        do_op(N'(5), N'(7), 1'b1, 1'b0, 0);
        do_op(N'(7), N'(5), 1'b1, 1'b0, 0);
        do_op(N'(7), N'(5), 1'b1, 1'b1, 0);
        do_op(smax, N'(1), 1'b0, 1'b0, 0);
        do_op(~smax, N'(1), 1'b1, 1'b0, 0);
        do_op(ones, ones, 1'b0, 1'b1, 3);
        do_op(rnd(), rnd(), 1'b0, 1'b0, 0);
        // Abort in the middle of RUN while word 2 is being processed
        accept(rnd(), rnd(), 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", N'(out_valid), N'(0));
        chk("abort_sum", out_sum, '0);
        chk("abort_busy", N'(busy), N'(0));
        chk("abort_in_ready", N'(in_ready), N'(1));
        @(negedge clk);
        rst_n = 1'b1;
        do_op(N'(3), N'(4), 1'b0, 1'b0, 0);
        for (int i = 0; i < 40; i++) begin
            logic [N-1:0] a, b;
            a = rnd();
            b = rnd();
            if (i % 8 == 1) b = ~a;
            if (i % 8 == 2) a = ones;
            do_op(a, b, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
